dmem_io_bus: RTL and testbench

DMEM_IO_BUS -- requirements
Module: dmem_io_bus

---
 rtl/dmem_io_bus_if.sv | 25 ++
 rtl/dmem_io_bus.sv | 157 +++++++++++++++
 tb/tb_dmem_io_bus.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_io_bus_if.sv
// Processor MEM-stage data bus: byte address, write data, enables and combinational read data.
// The master drives the request fields; the slave returns rdata in the same cycle.
interface dmem_io_bus_if;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        write;
  logic        read;

  modport master (
    output addr,
    output wdata,
    output write,
    output read,
    input  rdata
  );

  modport slave (
    input  addr,
    input  wdata,
    input  write,
    input  read,
    output rdata
  );
endinterface

// File: rtl/dmem_io_bus.sv
// Data RAM plus memory-mapped seven-segment display and two debounced switches.
// Reads are combinational and writes land on the clock edge; there is no backpressure.
module dmem_io_bus #(
  parameter int          RAM_WORDS = 128,
  parameter int          DEBOUNCE  = 4,
  parameter logic [15:0] DISP_ADDR = 16'hFFF0,
  parameter logic [15:0] SW0_ADDR  = 16'hFFF8,
  parameter logic [15:0] SW1_ADDR  = 16'hFFFA
) (
  input  logic         clock,
  input  logic         reset,
  dmem_io_bus_if.slave bus,
  output logic [6:0]   io_display,
  input  logic         io_sw0,
  input  logic         io_sw1
);

  localparam int          AW       = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [15:0] RAM_LAST = 16'(RAM_WORDS - 1);
  localparam logic [8:0]  DB_LIMIT = 9'(DEBOUNCE);

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_t;

  // Address decode; byte lane bit 0 never selects anything.
  logic          ram_hit;
  logic          disp_hit;
  logic          sw0_hit;
  logic          sw1_hit;
  logic [AW-1:0] widx;
  logic          unused_addr0;

  assign ram_hit      = ({1'b0, bus.addr[15:1]} <= RAM_LAST);
  assign disp_hit     = (bus.addr[15:1] == DISP_ADDR[15:1]);
  assign sw0_hit      = (bus.addr[15:1] == SW0_ADDR[15:1]);
  assign sw1_hit      = (bus.addr[15:1] == SW1_ADDR[15:1]);
  assign widx         = bus.addr[AW:1];
  assign unused_addr0 = bus.addr[0];

  logic [15:0] mem [RAM_WORDS];
  logic [3:0]  disp_reg;
  logic [1:0]  deb;
  logic [1:0]  sw_in;

  assign sw_in = {io_sw1, io_sw0};

  // RAM has no reset so its contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (!reset && bus.write && ram_hit) begin
      mem[widx] <= bus.wdata;
    end
  end

  always_comb begin
    bus.rdata = 16'h0000;
    if (bus.read) begin
      if (ram_hit) begin
        bus.rdata = mem[widx];
      end else if (sw0_hit) begin
        bus.rdata = {15'b0, deb[0]};
      end else if (sw1_hit) begin
        bus.rdata = {15'b0, deb[1]};
      end else if (disp_hit) begin
        bus.rdata = {12'b0, disp_reg};
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  // The segment register trails disp_reg by one edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      disp_reg   <= 4'h0;
      io_display <= 7'b0111111;
    end else begin
      io_display <= hex7(disp_reg);
      if (bus.write && disp_hit && !ram_hit) begin
        disp_reg <= bus.wdata[3:0];
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_db
    logic       s1;
    logic       s2;
    logic       deb_q;
    logic       deb_nx;
    db_state_t  state;
    db_state_t  state_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;
    logic [8:0] cnt_inc;

    always_ff @(posedge clock) begin
      if (reset) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        deb_q <= 1'b0;
        state <= STABLE;
        cnt   <= 8'd0;
      end else begin
        s1    <= sw_in[g];
        s2    <= s1;
        deb_q <= deb_nx;
        state <= state_nx;
        cnt   <= cnt_nx;
      end
    end

    // The count that would hold after this edge; accepting when it reaches the
    // limit gives exactly DEBOUNCE differing samples, and 9 bits avoid wrap.
    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      deb_nx   = deb_q;
      cnt_inc  = (state == STABLE) ? 9'd1 : ({1'b0, cnt} + 9'd1);
      if (s2 == deb_q) begin
        state_nx = STABLE;
        cnt_nx   = 8'd0;
      end else if (cnt_inc >= DB_LIMIT) begin
        deb_nx   = s2;
        state_nx = STABLE;
        cnt_nx   = 8'd0;
      end else begin
        state_nx = COUNTING;
        cnt_nx   = cnt_inc[7:0];
      end
    end

    assign deb[g] = deb_q;
  end

endmodule

// File: tb/tb_dmem_io_bus.sv
// Directed scenarios followed by randomized traffic, checked against a behavioural model.
module tb_dmem_io_bus;
  localparam int          D    = 4;
  localparam logic [15:0] DISP = 16'hFFF0;
  localparam logic [15:0] SW0  = 16'hFFF8;
  localparam logic [15:0] SW1  = 16'hFFFA;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] io_display;
  logic       io_sw0 = 1'b0;
  logic       io_sw1 = 1'b0;

  dmem_io_bus_if bus ();

  dmem_io_bus #(
    .RAM_WORDS(128),
    .DEBOUNCE (D),
    .DISP_ADDR(DISP),
    .SW0_ADDR (SW0),
    .SW1_ADDR (SW1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .io_display(io_display),
    .io_sw0    (io_sw0),
    .io_sw1    (io_sw1)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state.
  logic [15:0] m_ram [128];
  bit          m_known [128];
  logic [3:0]  m_disp = 4'h0;
  logic [6:0]  m_out = 7'h3F;
  bit          m_s1 [2];
  bit          m_s2 [2];
  bit          m_deb [2];
  logic [1:0]  hist [$];
  logic [6:0]  seg [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic model_read(output logic [15:0] v, output bit known);
    known = 1'b1;
    v     = 16'h0000;
    if (bus.read) begin
      if (bus.addr < 16'd256) begin
        known = m_known[bus.addr[7:1]];
        v     = m_ram[bus.addr[7:1]];
      end else if (bus.addr[15:1] == SW0[15:1]) v = {15'b0, m_deb[0]};
      else if (bus.addr[15:1] == SW1[15:1]) v = {15'b0, m_deb[1]};
      else if (bus.addr[15:1] == DISP[15:1]) v = {12'b0, m_disp};
    end
  endtask

  // A switch level is accepted once the last D synchronized samples all differ from it.
  task automatic model_edge();
    logic [1:0] samp;
    bit         all_diff;
    if (reset) begin
      m_disp = 4'h0;
      m_out  = 7'h3F;
      hist.delete();
      for (int c = 0; c < 2; c++) begin
        m_s1[c]  = 1'b0;
        m_s2[c]  = 1'b0;
        m_deb[c] = 1'b0;
      end
      return;
    end
    samp    = {m_s2[1], m_s2[0]};
    m_s2[0] = m_s1[0];
    m_s2[1] = m_s1[1];
    m_s1[0] = io_sw0;
    m_s1[1] = io_sw1;
    hist.push_back(samp);
    if (hist.size() > D) void'(hist.pop_front());
    for (int c = 0; c < 2; c++) begin
      if (hist.size() == D) begin
        all_diff = 1'b1;
        foreach (hist[i]) if (hist[i][c] == m_deb[c]) all_diff = 1'b0;
        if (all_diff) m_deb[c] = samp[c];
      end
    end
    m_out = seg[m_disp];
    if (bus.write) begin
      if (bus.addr < 16'd256) begin
        m_ram[bus.addr[7:1]]   = bus.wdata;
        m_known[bus.addr[7:1]] = 1'b1;
      end else if (bus.addr[15:1] == DISP[15:1]) begin
        m_disp = bus.wdata[3:0];
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic set(input logic [15:0] a, input logic [15:0] wd, input logic wr, input logic rd);
    bus.addr  = a;
    bus.wdata = wd;
    bus.write = wr;
    bus.read  = rd;
  endtask

  task automatic peek(input string tag, input logic [15:0] a, input logic [15:0] exp);
    set(a, 16'h0000, 1'b0, 1'b1);
    #1;
    check(tag, bus.rdata, exp);
  endtask

  // Check combinational read data and display against the model, then advance one edge.
  task automatic cycle(input string tag);
    logic [15:0] v;
    bit          k;
    #3;
    model_read(v, k);
    if (k) check({tag, "_rdata"}, bus.rdata, v);
    check({tag, "_disp"}, {9'b0, io_display}, {9'b0, m_out});
    tick();
  endtask

  initial begin
    logic [15:0] a;
    logic [3:0]  sel;
    set(16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_disp", {9'b0, io_display}, 16'h003F);
    peek("rst_sw0", SW0, 16'h0000);
    peek("rst_dispreg", DISP, 16'h0000);
    tick();

    // RAM write then read both byte lanes of the word
    set(16'h0010, 16'h1234, 1'b1, 1'b0);
    tick();
    peek("ram_rd10", 16'h0010, 16'h1234);
    peek("ram_rd11", 16'h0011, 16'h1234);
    set(16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();

    // Display write
    set(DISP, 16'h0008, 1'b1, 1'b0);
    tick();
    set(16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    check("disp8_seg", {9'b0, io_display}, 16'h007F);
    peek("disp8_rd", DISP, 16'h0008);

    // Clean sw0 edge: visible from the 6th edge
    io_sw0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      peek($sformatf("sw0_edge%0d", k), SW0, (k >= 6) ? 16'h0001 : 16'h0000);
    end

    // Short sw1 pulse is rejected
    io_sw1 = 1'b1;
    repeat (3) tick();
    io_sw1 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      peek($sformatf("sw1_pulse%0d", k), SW1, 16'h0000);
    end

    // Reset keeps RAM, clears I/O, ignores a write presented during reset
    set(16'h0004, 16'hBEEF, 1'b1, 1'b0);
    tick();
    set(16'h0006, 16'h2222, 1'b1, 1'b0);
    tick();
    set(DISP, 16'h0005, 1'b1, 1'b0);
    tick();
    set(16'h0006, 16'h1111, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set(16'h0000, 16'h0000, 1'b0, 1'b0);
    check("rstio_disp", {9'b0, io_display}, 16'h003F);
    peek("rstio_sw0", SW0, 16'h0000);
    peek("rstio_sw1", SW1, 16'h0000);
    peek("rstio_ram4", 16'h0004, 16'hBEEF);
    tick();
    peek("rstio_ram6", 16'h0006, 16'h2222);
    peek("rstio_dispreg", DISP, 16'h0000);
    tick();

    // Read-during-write and unmapped write
    set(16'h0020, 16'hAAAA, 1'b1, 1'b0);
    tick();
    set(16'h0020, 16'h5555, 1'b1, 1'b1);
    #1;
    check("rdw_same", bus.rdata, 16'hAAAA);
    tick();
    peek("rdw_next", 16'h0020, 16'h5555);
    set(16'h8000, 16'h1234, 1'b1, 1'b0);
    tick();
    peek("unmap_rd", 16'h8000, 16'h0000);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      sel = 4'($urandom_range(0, 7));
      case (sel)
        4'd0, 4'd1, 4'd2, 4'd3: a = 16'($urandom_range(0, 255));
        4'd4: a = DISP | 16'($urandom_range(0, 1));
        4'd5: a = SW0 | 16'($urandom_range(0, 1));
        4'd6: a = SW1 | 16'($urandom_range(0, 1));
        default: a = 16'($urandom);
      endcase
      set(a, 16'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 11) == 0) io_sw0 = ~io_sw0;
      if ($urandom_range(0, 11) == 0) io_sw1 = ~io_sw1;
      if ($urandom_range(0, 7) == 0) begin
        io_sw0 = ~io_sw0;
        io_sw1 = ~io_sw1;
      end
      reset = ($urandom_range(0, 99) == 0);
      cycle("rnd");
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
